// File: rtl/ts_queue_if.sv
// Push/pop/clear bus between timestamp capture, register block and ts_queue.
// Entry width (56) and status layout (8) are fixed by the register map.
interface ts_queue_if;
   logic        q_rst_in;
   logic        wr_en_in;
   logic [55:0] wr_data_in;
   logic        rd_en_in;
   logic [55:0] q_data_out;
   logic [7:0]  q_stat_out;

   modport master (
      output q_rst_in, wr_en_in, wr_data_in, rd_en_in,
      input  q_data_out, q_stat_out
   );

   modport slave (
      input  q_rst_in, wr_en_in, wr_data_in, rd_en_in,
      output q_data_out, q_stat_out
   );
endinterface

// File: rtl/ts_queue.sv
// Show-ahead timestamp FIFO with sticky overflow/underflow flags.
// Status and head data are combinational from registered state (zero latency).
module ts_queue #(
   parameter int ADDR_W = 4
) (
   input logic       clk,
   input logic       rst,
   ts_queue_if.slave qif
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);
   localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

   logic [55:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   level, level_nxt;
   logic              ovf, udf;
   logic              full, empty, clr, do_push, do_pop;
   logic [4:0]        level_ext;

   assign full  = (level == FULL_LVL);
   assign empty = (level == '0);
   assign clr   = rst | qif.q_rst_in;

   // A pop on a full queue frees the slot the simultaneous push lands in.
   assign do_pop  = !clr && qif.rd_en_in && !empty;
   assign do_push = !clr && qif.wr_en_in && (!full || qif.rd_en_in);

   always_comb begin
      level_nxt = level;
      case ({do_push, do_pop})
         2'b10:   level_nxt = level + LVL_ONE;
         2'b01:   level_nxt = level - LVL_ONE;
         default: level_nxt = level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         level <= level_nxt;
         if (qif.wr_en_in && full && !qif.rd_en_in) ovf <= 1'b1;
         if (qif.rd_en_in && empty)                 udf <= 1'b1;
      end
   end

   // Storage is not reset; stale entries are masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= qif.wr_data_in;
   end

   assign level_ext      = 5'(level);
   assign qif.q_stat_out = {ovf, udf, full, level_ext};
   assign qif.q_data_out = empty ? 56'd0 : mem[rd_ptr];
endmodule

// File: doc/ts_queue.md
TS_QUEUE -- requirements
Module: ts_queue

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set queue depth = 2**ADDR_W entries; legal range 2..4.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 Port q_rst_in  input  1  one-cycle queue-clear pulse from register block (rx_q_rst_out/tx_q_rst_out).
REQ-005 Port wr_en_in  input  1  push request from timestamp capture logic.
REQ-006 Port wr_data_in  input  56  timestamp to push: {sec[15:0], ns[29:0], msgid[9:0]} packing owned by capture logic; queue treats it as opaque.
REQ-007 Port rd_en_in  input  1  one-cycle pop pulse from register block (rx_q_rd_en_out/tx_q_rd_en_out).
REQ-008 Port q_data_out  output  56  head (oldest) entry, show-ahead.
REQ-009 Port q_stat_out  output  8  {ovf, udf, full, level[4:0]}.

Function
REQ-010 Storage SHALL be a 2**ADDR_W x 56 register array with ADDR_W-bit write and read pointers and an (ADDR_W+1)-bit level counter.
REQ-011 Pointers SHALL wrap modulo 2**ADDR_W; wrap SHALL NOT affect data order.
REQ-012 full = (level == 2**ADDR_W); empty = (level == 0).
REQ-013 Push, not full: wr_data_in written at write pointer; write pointer +1; level +1.
REQ-014 Push, full, no pop: entry discarded; contents and pointers unchanged; ovf set.
REQ-015 Pop, not empty: read pointer +1; level -1.
REQ-016 Pop, empty: ignored; udf set.
REQ-017 Push and pop same cycle, 0 < level < full: both performed; level unchanged.
REQ-018 Push and pop same cycle, full: pop performed and push accepted into freed slot; level stays full; ovf NOT set.
REQ-019 Push and pop same cycle, empty: push performed, pop counts as underflow; level becomes 1; udf set.
REQ-020 ovf and udf SHALL be sticky; cleared only by rst or q_rst_in.
REQ-021 q_stat_out and q_data_out SHALL be combinational from registered state: values valid from the edge on which the operation takes effect (zero added latency).
REQ-022 q_data_out SHALL equal array[read pointer] when not empty, and 56'd0 when empty.
REQ-023 level[4:0] SHALL be zero-extended when ADDR_W < 4; unused stat bits are 0.

Reset
REQ-024 rst or q_rst_in SHALL clear pointers, level, ovf, udf; q_stat_out = 8'h00 and q_data_out = 0 on the following cycle.
REQ-025 Reset SHALL take priority over simultaneous push/pop; those requests are discarded.
REQ-026 Array contents SHALL NOT be cleared by reset; they are unobservable while empty.
REQ-027 Reset mid-operation (queue partly full) SHALL discard all entries; the next push becomes head.

Verification
REQ-028 Assert rst 2 cycles -> q_stat_out 8'h00, q_data_out 0; no X on outputs.
REQ-029 Push 56'h11, then 56'h22; pop once -> stat 8'h01, 8'h02, 8'h01; q_data_out 56'h11, 56'h11, 56'h22.
REQ-030 ADDR_W=4: push values 1..16, then push 56'hFF -> stat 8'hB0, head 1; pop 16 times -> data 1..16 in order, final stat 8'h80.
REQ-031 Pop on empty -> stat 8'h40, q_data_out 0; then push 56'h5 with pop same cycle -> stat 8'h41, head 5.
REQ-032 Full (1..16) with simultaneous push 56'h99 and pop -> stat 8'h30, head 2; pop 15 more -> last entry 56'h99, stat 8'h01 (then empty after one more pop).
REQ-033 Level 3 with q_rst_in and wr_en_in in same cycle -> stat 8'h00 next cycle; next push 56'h7 -> head 7, stat 8'h01.
